// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular-exponentiation sequencer and mon_prod:
// operation codes, the sequencer state encoding and default operand widths.
package mod_exp_pkg;

  localparam int BITLEN_DEF     = 512;
  localparam int LOG_BITLEN_DEF = 9;

  typedef logic [1:0] op_code_t;

  // Operation codes understood by mon_prod
  localparam op_code_t OPXX = 2'd0;  // x_bar * x_bar
  localparam op_code_t OPXM = 2'd1;  // x_bar * M_bar
  localparam op_code_t OPX1 = 2'd2;  // x_bar * 1, leaves Montgomery form

  // Sequencer state encoding
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SCAN      = 4'd1;
  localparam logic [3:0] S_SQ_ISSUE  = 4'd2;
  localparam logic [3:0] S_SQ_WAIT   = 4'd3;
  localparam logic [3:0] S_MUL_ISSUE = 4'd4;
  localparam logic [3:0] S_MUL_WAIT  = 4'd5;
  localparam logic [3:0] S_NEXT      = 4'd6;
  localparam logic [3:0] S_FIN_ISSUE = 4'd7;
  localparam logic [3:0] S_FIN_WAIT  = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

  // Operation launched by an issue state
  function automatic op_code_t opForState(input logic [3:0] st);
    op_code_t op;
    op = OPXX;
    case (st)
      S_MUL_ISSUE: op = OPXM;
      S_FIN_ISSUE: op = OPX1;
      default:     op = OPXX;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mod_exp_ctrl_mp_edge_det.sv
// Completion detector for mon_prod: mon_prod holds stop high between
// operations, so a finished operation shows up as a rising edge of stop.
module mp_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_mp_stop,
  output logic o_complete
);

  logic r_stop_q;

  // Delay stop by one cycle so its rising edge can be spotted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stop_q <= 1'b0;
    end else begin
      r_stop_q <= i_mp_stop;
    end
  end

  assign o_complete = i_mp_stop & ~r_stop_q;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply sequencer driving mon_prod. Walks the exponent MSB
// first: a square for every processed bit, a multiply by M_bar for every
// 1 bit, then a final multiply by 1 to leave Montgomery form.
// Optional feature: MOD_EXP_SKIP_ZEROS_EN skips leading zero exponent bits
// (squares of R are identity) before the first square is issued.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int BITLEN     = BITLEN_DEF,
  parameter int LOG_BITLEN = LOG_BITLEN_DEF,
  parameter int MP_COUNT   = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [BITLEN-1:0]     exp_in,
  input  logic [LOG_BITLEN:0]   exp_len,
  input  logic                  mp_stop,
  output logic                  mp_start,
  output logic [1:0]            mp_op_code,
  output logic [LOG_BITLEN:0]   mp_count,
  output logic                  busy,
  output logic                  done,
  output logic [LOG_BITLEN+2:0] op_cnt
);

  localparam logic [LOG_BITLEN:0]   LP_BITLEN  = (LOG_BITLEN+1)'(BITLEN);
  localparam logic [LOG_BITLEN-1:0] LP_IDX_MAX = LOG_BITLEN'(BITLEN - 1);

  logic [3:0]            r_state;
  logic [BITLEN-1:0]     r_exp;
  logic [LOG_BITLEN-1:0] r_idx;
  op_code_t              r_op_code;
  logic [LOG_BITLEN+2:0] r_op_cnt;
  logic                  r_busy;
  logic                  r_done;

  logic w_complete;
  logic w_issue;
  logic w_bit;

  mp_edge_det u_edge_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mp_stop  (mp_stop),
    .o_complete (w_complete)
  );

  assign w_issue = (r_state == S_SQ_ISSUE) || (r_state == S_MUL_ISSUE) ||
                   (r_state == S_FIN_ISSUE);
  assign w_bit   = r_exp[r_idx];

  // The op code is shown combinationally during the issue cycle and then
  // held in a register until the next issue, including through IDLE.
  assign mp_start   = w_issue;
  assign mp_op_code = w_issue ? opForState(r_state) : r_op_code;
  assign mp_count   = (LOG_BITLEN+1)'(MP_COUNT);
  assign busy       = r_busy;
  assign done       = r_done;
  assign op_cnt     = r_op_cnt;

  // Main sequencer: stop edges are only honoured in the wait states, so a
  // late edge from an op abandoned by reset is harmlessly ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_exp     <= '0;
      r_idx     <= '0;
      r_op_code <= OPXX;
      r_op_cnt  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_exp    <= exp_in;
            r_idx    <= (exp_len > LP_BITLEN) ? LP_IDX_MAX
                                              : (exp_len[LOG_BITLEN-1:0] - 1'b1);
            r_op_cnt <= '0;
            r_busy   <= 1'b1;
            if (exp_len == '0) begin
              r_state <= S_FIN_ISSUE;
            end else begin
`ifdef MOD_EXP_SKIP_ZEROS_EN
              r_state <= S_SCAN;
`else
              r_state <= S_SQ_ISSUE;
`endif
            end
          end
        end
`ifdef MOD_EXP_SKIP_ZEROS_EN
        S_SCAN: begin
          if (w_bit) begin
            r_state <= S_SQ_ISSUE;
          end else if (r_idx == '0) begin
            r_state <= S_FIN_ISSUE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
`endif
        S_SQ_ISSUE: begin
          r_op_code <= OPXX;
          r_op_cnt  <= r_op_cnt + 1'b1;
          r_state   <= S_SQ_WAIT;
        end
        S_SQ_WAIT: begin
          if (w_complete) begin
            r_state <= w_bit ? S_MUL_ISSUE : S_NEXT;
          end
        end
        S_MUL_ISSUE: begin
          r_op_code <= OPXM;
          r_op_cnt  <= r_op_cnt + 1'b1;
          r_state   <= S_MUL_WAIT;
        end
        S_MUL_WAIT: begin
          if (w_complete) begin
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_idx == '0) begin
            r_state <= S_FIN_ISSUE;
          end else begin
            r_idx   <= r_idx - 1'b1;
            r_state <= S_SQ_ISSUE;
          end
        end
        S_FIN_ISSUE: begin
          r_op_code <= OPX1;
          r_op_cnt  <= r_op_cnt + 1'b1;
          r_state   <= S_FIN_WAIT;
        end
        S_FIN_WAIT: begin
          if (w_complete) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl with a mon_prod stub that drops stop
// on start and raises it again three cycles later. Expected op sequences come
// from a square-and-multiply model over the exponent bits.
// Honours MOD_EXP_SKIP_ZEROS_EN to match the build of the design.
module tb_mod_exp_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         go = 1'b0;
  logic [511:0] exp_in = '0;
  logic [9:0]   exp_len = '0;
  logic         mp_stop = 1'b1;
  logic         mp_start;
  logic [1:0]   mp_op_code;
  logic [9:0]   mp_count;
  logic         busy;
  logic         done;
  logic [11:0]  op_cnt;

  int    compared = 0;
  int    mismatched = 0;
  int    cyc = 0;
  int    stubCnt = 0;
  int    lastStopRise = 0;
  int    doneCnt = 0;
  string capStr = "";

  always #5 clk = ~clk;

  mod_exp_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .exp_in     (exp_in),
    .exp_len    (exp_len),
    .mp_stop    (mp_stop),
    .mp_start   (mp_start),
    .mp_op_code (mp_op_code),
    .mp_count   (mp_count),
    .busy       (busy),
    .done       (done),
    .op_cnt     (op_cnt)
  );

  // mon_prod stub: no reset, finishes any op it has started
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mp_start) begin
      mp_stop <= 1'b0;
      stubCnt <= 3;
    end else if (stubCnt != 0) begin
      stubCnt <= stubCnt - 1;
      if (stubCnt == 1) begin
        mp_stop      <= 1'b1;
        lastStopRise <= cyc + 1;
      end
    end
  end

  // Record every issued op and every done pulse
  always @(negedge clk) begin
    if (mp_start) begin
      case (mp_op_code)
        2'd0:    capStr <= {capStr, "XX "};
        2'd1:    capStr <= {capStr, "XM "};
        2'd2:    capStr <= {capStr, "X1 "};
        default: capStr <= {capStr, "?? "};
      endcase
    end
    if (done) doneCnt <= doneCnt + 1;
  end

  // Reference: square every processed bit, multiply on each 1, finish with X1
  function automatic string expOps(input logic [511:0] e, input int len);
    string s;
    int    n;
    bit    seen;
    s    = "";
    seen = 1'b0;
    n    = (len > 512) ? 512 : len;
    for (int i = n - 1; i >= 0; i--) begin
`ifdef MOD_EXP_SKIP_ZEROS_EN
      if (!seen && !e[i]) continue;
`endif
      seen = 1'b1;
      s = {s, "XX "};
      if (e[i]) s = {s, "XM "};
    end
    s = {s, "X1 "};
    return s;
  endfunction

  function automatic string clip(input string s);
    return (s.len() > 60) ? s.substr(0, 59) : s;
  endfunction

  function automatic logic [511:0] randExp();
    logic [511:0] e;
    for (int w = 0; w < 16; w++) e[w*32 +: 32] = $urandom;
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Launch one exponentiation and collect what the DUT did until done
  task automatic runExp(input logic [511:0] e, input logic [9:0] len,
                        input int goAgainAt, output string ops,
                        output int cntAtDone, output int busyDuring,
                        output int busyAtDone, output int gap,
                        output int dones, output bit timedOut);
    int capBase;
    int doneBase;
    tick();
    capBase  = capStr.len();
    doneBase = doneCnt;
    exp_in   = e;
    exp_len  = len;
    go       = 1'b1;
    tick();
    go         = 1'b0;
    busyDuring = int'(busy);
    timedOut   = 1'b1;
    cntAtDone  = -1;
    busyAtDone = -1;
    gap        = -1;
    for (int i = 0; i < 20000; i++) begin
      tick();
      go = (i == goAgainAt);
      if (go) begin
        exp_in  = ~e;
        exp_len = 10'd3;
      end
      if (done) begin
        cntAtDone  = int'(op_cnt);
        busyAtDone = int'(busy);
        gap        = cyc - lastStopRise;
        timedOut   = 1'b0;
        break;
      end
    end
    go = 1'b0;
    tick();
    tick();
    dones = doneCnt - doneBase;
    ops   = (capStr.len() > capBase) ? capStr.substr(capBase, capStr.len() - 1) : "";
  endtask

  task automatic test_reset();
    tick();
    compared += 5;
    if (mp_start !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mp_start: got %0b expected 0", mp_start); end
    if (mp_op_code !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_op_code: got %0d expected 0", mp_op_code); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    if (op_cnt !== 12'd0) begin mismatched++; $display("[TB] FAIL reset_op_cnt: got %0d expected 0", op_cnt); end
    rst_n = 1'b1;
    repeat (3) tick();
    compared += 2;
    if (mp_count !== 10'd512) begin mismatched++; $display("[TB] FAIL mp_count: got %0d expected 512", mp_count); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_sequences();
    logic [511:0] eTab[8];
    int           lTab[8];
    string        ops, expStr;
    int           cnt, bDur, bDone, gap, dones;
    bit           tmo;
    eTab[0] = 512'hB;  lTab[0] = 4;
    eTab[1] = 512'h3;  lTab[1] = 4;
    eTab[2] = '0;      lTab[2] = 6;
    eTab[3] = 512'h1;  lTab[3] = 1;
    eTab[4] = randExp(); lTab[4] = 512;
    eTab[5] = randExp(); lTab[5] = 700;
    eTab[6] = randExp(); lTab[6] = int'($urandom_range(1, 40));
    eTab[7] = randExp(); lTab[7] = int'($urandom_range(1, 40));
    for (int k = 0; k < 8; k++) begin
      runExp(eTab[k], lTab[k][9:0], -1, ops, cnt, bDur, bDone, gap, dones, tmo);
      expStr = expOps(eTab[k], lTab[k]);
      compared += 5;
      if (tmo) begin mismatched++; $display("[TB] FAIL seq%0d_timeout: got no done expected done", k); end
      if (ops != expStr) begin mismatched++; $display("[TB] FAIL seq%0d_ops: got %s expected %s", k, clip(ops), clip(expStr)); end
      if (cnt != expStr.len() / 3) begin mismatched++; $display("[TB] FAIL seq%0d_op_cnt: got %0d expected %0d", k, cnt, expStr.len() / 3); end
      if (dones != 1) begin mismatched++; $display("[TB] FAIL seq%0d_done_pulses: got %0d expected 1", k, dones); end
      if (bDur != 1 || bDone != 0) begin mismatched++; $display("[TB] FAIL seq%0d_busy: got %0d/%0d expected 1/0", k, bDur, bDone); end
    end
  endtask

  task automatic test_zero_len();
    string ops;
    int    cnt, bDur, bDone, gap, dones;
    bit    tmo;
    runExp(randExp(), 10'd0, -1, ops, cnt, bDur, bDone, gap, dones, tmo);
    compared += 4;
    if (ops != "X1 ") begin mismatched++; $display("[TB] FAIL zero_len_ops: got %s expected X1", clip(ops)); end
    if (cnt != 1) begin mismatched++; $display("[TB] FAIL zero_len_op_cnt: got %0d expected 1", cnt); end
    if (gap != 2) begin mismatched++; $display("[TB] FAIL zero_len_done_latency: got %0d expected 2", gap); end
    if (dones != 1 || tmo) begin mismatched++; $display("[TB] FAIL zero_len_done: got %0d pulses expected 1", dones); end
  endtask

  task automatic test_go_while_busy();
    string ops, expStr;
    int    cnt, bDur, bDone, gap, dones;
    bit    tmo;
    runExp(512'hB, 10'd4, 1, ops, cnt, bDur, bDone, gap, dones, tmo);
    expStr = expOps(512'hB, 4);
    repeat (10) tick();
    compared += 3;
    if (ops != expStr) begin mismatched++; $display("[TB] FAIL busy_go_ops: got %s expected %s", clip(ops), clip(expStr)); end
    if (cnt != 8 || tmo) begin mismatched++; $display("[TB] FAIL busy_go_op_cnt: got %0d expected 8", cnt); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL busy_go_requeued: got busy %0b expected 0", busy); end
  endtask

  task automatic test_mid_run_reset();
    int    base;
    bit    found;
    string ops, expStr;
    int    cnt, bDur, bDone, gap, dones;
    bit    tmo;
    tick();
    base    = capStr.len();
    exp_in  = 512'hB;
    exp_len = 10'd4;
    go      = 1'b1;
    tick();
    go    = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (capStr.len() - base >= 6) begin found = 1'b1; break; end
      tick();
    end
    compared++;
    if (!found) begin mismatched++; $display("[TB] FAIL rst_reach_mul: got %0d ops expected 2", (capStr.len() - base) / 3); end
    tick();
    rst_n = 1'b0;
    #1;
    compared += 5;
    if (mp_start !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mp_start: got %0b expected 0", mp_start); end
    if (mp_op_code !== 2'd0) begin mismatched++; $display("[TB] FAIL rst_op_code: got %0d expected 0", mp_op_code); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %0b expected 0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_done: got %0b expected 0", done); end
    if (op_cnt !== 12'd0) begin mismatched++; $display("[TB] FAIL rst_op_cnt: got %0d expected 0", op_cnt); end
    tick();
    tick();
    rst_n = 1'b1;
    base  = capStr.len();
    repeat (10) tick();
    compared++;
    if (capStr.len() != base) begin mismatched++; $display("[TB] FAIL rst_late_stop: got %0d starts expected 0", (capStr.len() - base) / 3); end
    runExp(512'h1, 10'd1, -1, ops, cnt, bDur, bDone, gap, dones, tmo);
    expStr = expOps(512'h1, 1);
    compared += 2;
    if (ops != expStr || tmo) begin mismatched++; $display("[TB] FAIL rst_rerun_ops: got %s expected %s", clip(ops), clip(expStr)); end
    if (cnt != 3) begin mismatched++; $display("[TB] FAIL rst_rerun_op_cnt: got %0d expected 3", cnt); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] e;
    int           l;
    string        ops, expStr;
    int           cnt, bDur, bDone, gap, dones;
    bit           tmo;
    for (int k = 0; k < 4; k++) begin
      e = randExp();
      l = int'($urandom_range(1, 24));
      runExp(e, l[9:0], -1, ops, cnt, bDur, bDone, gap, dones, tmo);
      expStr = expOps(e, l);
      compared += 2;
      if (ops != expStr || tmo) begin mismatched++; $display("[TB] FAIL b2b%0d_ops: got %s expected %s", k, clip(ops), clip(expStr)); end
      if (cnt != expStr.len() / 3 || dones != 1) begin mismatched++; $display("[TB] FAIL b2b%0d_op_cnt: got %0d expected %0d", k, cnt, expStr.len() / 3); end
    end
  endtask

  initial begin
    $display("[TB] starting mod_exp_ctrl bench");
    test_reset();
    test_sequences();
    test_zero_len();
    test_go_while_busy();
    test_mid_run_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Square-and-multiply sequencer that sits directly upstream of mon_prod and drives its start/op_code/mp_count inputs.
- Walks the exponent MSB-first, issuing OPXX (square) for every bit and OPXM (multiply by M_bar) for every 1 bit, then OPX1 to leave Montgomery form.
- Operands live in the shared RAM: x_bar at addr 0, M_bar at addr 2. This block never touches RAM data; it only sequences operations.

Parameters:
- BITLEN, 512, operand/exponent width.
- LOG_BITLEN, 9, width of the exponent-length field minus one.
- MP_COUNT, 512, iteration count driven to mon_prod mp_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  one-cycle request; honoured only in IDLE.
- exp_in  in  BITLEN  exponent; sampled on accepted go.
- exp_len  in  LOG_BITLEN+1  number of significant exponent bits; sampled on accepted go.
- mp_stop  in  1  mon_prod stop (level, held high between ops).
- mp_start  out  1  one-cycle start pulse to mon_prod.
- mp_op_code  out  2  0=OPXX, 1=OPXM, 2=OPX1; stable from start pulse until completion.
- mp_count  out  LOG_BITLEN+1  constant MP_COUNT.
- busy  out  1  high from accepted go until done.
- done  out  1  one-cycle pulse when the final OPX1 completes.
- op_cnt  out  LOG_BITLEN+3  mon_prod operations issued in the current run.

Behaviour:
- Reset values: mp_start=0, mp_op_code=0, busy=0, done=0, op_cnt=0, state=IDLE, stop_q=0.
- Completion detection: stop_q registers mp_stop every cycle. An op completes on the rising edge mp_stop & ~stop_q, observed while in a *_WAIT state. Rising edges seen in any other state are ignored.
- States: IDLE, SCAN, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, FIN_ISSUE, FIN_WAIT, DONE.
- IDLE: on go, latch exp_in into e_reg. Set idx = min(exp_len, BITLEN) - 1. Clear op_cnt and set busy=1. If exp_len==0, go to FIN_ISSUE; otherwise go to SCAN (macro on) or SQ_ISSUE (macro off).
- *_ISSUE: mp_start=1 for exactly this cycle, drive mp_op_code, op_cnt+1, then go to the matching *_WAIT.
- SQ_WAIT: on completion, go to MUL_ISSUE if e_reg[idx]==1, else go to NEXT.
- MUL_WAIT: on completion, go to NEXT.
- NEXT: if idx==0 go to FIN_ISSUE; else idx-1 and go to SQ_ISSUE.
- FIN_WAIT: on completion, go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- go while busy: ignored, with no queueing.
- mp_op_code holds its last value in IDLE.
- Min spacing: one idle cycle between completion and the next mp_start, so mon_prod is always back in IDLE.
- Reset mid-run: immediately IDLE with all outputs at reset values. mon_prod has no reset and may finish an in-flight op; the resulting stop edge is ignored in IDLE. Software must reload x_bar before the next go.
- Op count per run = 1 + (number of processed bits) + (number of 1s among processed bits).

Optional Feature:
- Macro: MOD_EXP_SKIP_ZEROS_EN.
- Defined: SCAN state decrements idx one bit per cycle while e_reg[idx]==0 && idx!=0, issuing no ops.
  - First 1 found: go to SQ_ISSUE.
  - idx reaches 0 with bit 0 = 0: go to FIN_ISSUE.
  - Leading squares of R are identity, so results are unchanged; only op_cnt and latency drop.
- Undefined: SCAN is unreachable and every one of exp_len bits is squared.

Decomposition:
- Shared package mod_exp_pkg holds:
  - op codes OPXX/OPXM/OPX1, also used by mon_prod;
  - state encoding;
  - BITLEN/LOG_BITLEN defaults.
- One natural sub-module, mp_edge_det: registers mp_stop and emits the completion pulse. Everything else stays flat.

Test Plan:
- Bench model: mon_prod stub that clears stop on start and raises it 3 cycles later. Checks mp_op_code at each start.
- exp_in=4'b1011, exp_len=4, macro off -> ops XX,XM,XX,XX,XM,XX,XM,X1; op_cnt=8; one done pulse; busy low after done.
- exp_in=4'b0011, exp_len=4 -> off: XX,XX,XX,XM,XX,XM,X1 (op_cnt=7); on: XX,XM,XX,XM,X1 (op_cnt=5), with 2 SCAN cycles.
- exp_len=0 -> single X1, op_cnt=1, done 2 cycles after that op completes.
- go pulsed during SQ_WAIT -> no effect; op sequence and op_cnt unchanged.
- rst_n low during MUL_WAIT -> outputs reset asynchronously. A late stub stop edge produces no mp_start. A fresh go with exp_in=1, exp_len=1 -> XX,XM,X1.
